// File: rtl/pad_ctrl_seq_if.sv
// Register-bus bundle between the SoC bus and the pad controller.
// Signal suffixes are named from the controller's point of view.
interface pad_ctrl_seq_if #(
    parameter int AW = 4
);
    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   wdata_i;
    logic          gnt_o;
    logic          rvalid_o;
    logic [31:0]   rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/pad_ctrl_seq.sv
// Core-side padframe controller: per-pad config registers, pad_y synchroniser,
// and a power-up sequencer that gates the pad control pins until IO power is stable.
module pad_ctrl_seq #(
    parameter int NumPads      = 8,
    parameter int StableCycles = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    pad_ctrl_seq_if.slave      bus,
    input  logic               sns_i,
    input  logic               rto_i,
    input  logic [NumPads-1:0] pad_y_i,
    output logic [NumPads-1:0] pad_a_o,
    output logic [NumPads-1:0] pad_oe_o,
    output logic [NumPads-1:0] pad_ie_o,
    output logic [NumPads-1:0] pad_pe_o,
    output logic [NumPads-1:0] pad_ps_o,
    output logic [NumPads-1:0] pad_ds0_o,
    output logic [NumPads-1:0] pad_ds1_o,
    output logic [NumPads-1:0] pad_sr_o,
    output logic [NumPads-1:0] pad_is_o,
    output logic [1:0]         state_o
);

    localparam int AW = $clog2(NumPads + 1);
    localparam int CW = $clog2(StableCycles + 1);
    localparam logic [CW-1:0] CntLast = CW'(StableCycles - 1);

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        WAIT_PWR = 2'd1,
        IN_EN    = 2'd2,
        ACTIVE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [8:0]          cfg_q [NumPads];
    logic [NumPads-1:0]  sy1_q, sy2_q;
    logic                rvalid_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                pwr_ok;
    logic                in_gate, out_gate;
    logic [7:0]          cnt_view;

    logic [NumPads-1:0]  cfg_oe, cfg_ie, cfg_pe, cfg_ps, cfg_ds0, cfg_ds1, cfg_sr, cfg_is, cfg_a;
    logic [NumPads-1:0]  a_d, oe_d, ie_d, pe_d, ps_d, ds0_d, ds1_d, sr_d, is_d;
    logic [NumPads-1:0]  a_q, oe_q, ie_q, pe_q, ps_q, ds0_q, ds1_q, sr_q, is_q;

    logic                unused_wdata;
    assign unused_wdata = ^bus.wdata_i[31:9];

    assign pwr_ok = sns_i & rto_i;

    // Sequencer state and stability counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencer next state: any power loss falls straight back to OFF
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                cnt_d = '0;
                if (pwr_ok) state_d = WAIT_PWR;
            end
            WAIT_PWR: begin
                if (!pwr_ok) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = IN_EN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IN_EN: begin
                if (!pwr_ok) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!pwr_ok) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer outputs: pin gating derived from the current state
    always_comb begin
        in_gate  = (state_q == IN_EN) || (state_q == ACTIVE);
        out_gate = (state_q == ACTIVE);
        ie_d  = in_gate  ? cfg_ie  : '0;
        pe_d  = in_gate  ? cfg_pe  : '0;
        ps_d  = in_gate  ? cfg_ps  : '0;
        is_d  = in_gate  ? cfg_is  : '0;
        oe_d  = out_gate ? cfg_oe  : '0;
        a_d   = out_gate ? cfg_a   : '0;
        ds0_d = out_gate ? cfg_ds0 : '0;
        ds1_d = out_gate ? cfg_ds1 : '0;
        sr_d  = out_gate ? cfg_sr  : '0;
    end

    // Unpack config registers into per-field pin vectors
    always_comb begin
        for (int i = 0; i < NumPads; i++) begin
            cfg_oe[i]  = cfg_q[i][0];
            cfg_ie[i]  = cfg_q[i][1];
            cfg_pe[i]  = cfg_q[i][2];
            cfg_ps[i]  = cfg_q[i][3];
            cfg_ds0[i] = cfg_q[i][4];
            cfg_ds1[i] = cfg_q[i][5];
            cfg_sr[i]  = cfg_q[i][6];
            cfg_is[i]  = cfg_q[i][7];
            cfg_a[i]   = cfg_q[i][8];
        end
    end

    // Registered pad control pins
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q   <= '0;
            oe_q  <= '0;
            ie_q  <= '0;
            pe_q  <= '0;
            ps_q  <= '0;
            ds0_q <= '0;
            ds1_q <= '0;
            sr_q  <= '0;
            is_q  <= '0;
        end else begin
            a_q   <= a_d;
            oe_q  <= oe_d;
            ie_q  <= ie_d;
            pe_q  <= pe_d;
            ps_q  <= ps_d;
            ds0_q <= ds0_d;
            ds1_q <= ds1_d;
            sr_q  <= sr_d;
            is_q  <= is_d;
        end
    end

    // Config register writes; out-of-range addresses match no pad
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumPads; i++) cfg_q[i] <= 9'h002;
        end else if (bus.req_i && bus.we_i) begin
            for (int i = 0; i < NumPads; i++) begin
                if (bus.addr_i == AW'(i)) cfg_q[i] <= bus.wdata_i[8:0];
            end
        end
    end

    // Two-flop synchroniser for the asynchronous pad inputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sy1_q <= '0;
            sy2_q <= '0;
        end else begin
            sy1_q <= pad_y_i;
            sy2_q <= sy1_q;
        end
    end

    // Status view of the stability counter, clamped to its 8-bit field
    always_comb begin
        if (32'(cnt_q) > 32'd255) cnt_view = 8'hFF;
        else                      cnt_view = 8'(cnt_q);
    end

    // Read data mux; writes and unmapped reads respond with zero
    always_comb begin
        rdata_d = '0;
        if (bus.req_i && !bus.we_i) begin
            if (bus.addr_i == AW'(NumPads)) begin
                rdata_d[1:0]  = state_q;
                rdata_d[15:8] = cnt_view;
            end else begin
                for (int i = 0; i < NumPads; i++) begin
                    if (bus.addr_i == AW'(i)) begin
                        rdata_d[8:0] = cfg_q[i];
                        rdata_d[16]  = sy2_q[i];
                    end
                end
            end
        end
    end

    // One-cycle response register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= bus.req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign state_o      = state_q;

    assign pad_a_o   = a_q;
    assign pad_oe_o  = oe_q;
    assign pad_ie_o  = ie_q;
    assign pad_pe_o  = pe_q;
    assign pad_ps_o  = ps_q;
    assign pad_ds0_o = ds0_q;
    assign pad_ds1_o = ds1_q;
    assign pad_sr_o  = sr_q;
    assign pad_is_o  = is_q;

endmodule
